// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the barrel-shifter family: FSM state encodings and
// the rotate-amount width derivation used by the left and right variants.
package barrel_shifter_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_SHIFT = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE  = 2'd2;

    // Amount width for an n-bit word; never narrower than one bit.
    function automatic int amt_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/rotation_left_stage.sv
// One log2 barrel stage: rotates left by 2^(i_k + STAGE) when enabled,
// otherwise passes the word through unchanged.
module rotation_left_stage
    import barrel_shifter_pkg::*;
#(
    parameter int N     = 8,
    parameter int STAGE = 0,
    localparam int SHW  = amt_width(N)
) (
    input  logic [N-1:0]   i_data,
    input  logic [SHW-1:0] i_k,
    input  logic           i_en,
    output logic [N-1:0]   o_data
);

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            // Selecting among the fixed rotations keeps every shift constant.
            for (int s = 0; s < SHW; s++) begin
                if ((int'(i_k) + STAGE) == s) begin
                    o_data = (i_data << (1 << s)) | (i_data >> (N - (1 << s)));
                end
            end
        end
    end

endmodule

// File: rtl/rotation_left_shifter_seq.sv
// Multi-cycle rotate-left unit: one barrel stage per clock between a
// valid/ready request port and a valid/ready result port.
module rotation_left_shifter_seq
    import barrel_shifter_pkg::*;
#(
    parameter int N    = 8,
    localparam int SHW = amt_width(N)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [N-1:0]   i_num,
    input  logic [SHW-1:0] i_num_bit_rotation,
    input  logic           i_valid,
    output logic           o_ready,
    output logic [N-1:0]   o_result,
    output logic           o_valid,
    input  logic           i_ready,
    output logic           o_busy
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; o_ready is high only in IDLE, o_valid only in DONE.

    localparam logic [SHW-1:0] K_LAST = SHW'(SHW - 1);
    localparam logic [SHW-1:0] K_ONE  = SHW'(1);

    logic [ST_W-1:0] state_q, state_d;
    logic [SHW-1:0]  k_q, k_d;
    logic [N-1:0]    work_q, work_d;
    logic [SHW-1:0]  amt_q, amt_d;
    logic [N-1:0]    result_q, result_d;
    logic            valid_q, valid_d;
    logic [N-1:0]    stage_out;

    rotation_left_stage #(
        .N     (N),
        .STAGE (0)
    ) u_stage (
        .i_data (work_q),
        .i_k    (k_q),
        .i_en   (amt_q[k_q]),
        .o_data (stage_out)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        work_d   = work_q;
        amt_d    = amt_q;
        result_d = result_q;
        valid_d  = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    work_d  = i_num;
                    amt_d   = i_num_bit_rotation;
                    k_d     = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                work_d = stage_out;
                k_d    = k_q + K_ONE;
                // Every amount walks all stages so latency is fixed.
                if (k_q == K_LAST) begin
                    result_d = stage_out;
                    valid_d  = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            work_q   <= '0;
            amt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            work_q   <= work_d;
            amt_q    <= amt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ready  = (state_q == ST_IDLE);
    assign o_busy   = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign o_result = result_q;
    assign o_valid  = valid_q;

endmodule

// File: tb/tb_rotation_left_shifter_seq.sv
// Bench for rotation_left_shifter_seq: directed and random rotations checked
// against an arithmetic rotate model, plus backpressure, reset and streaming.
module tb_rotation_left_shifter_seq;

    localparam int N   = 8;
    localparam int SHW = 3;

    logic           i_clk;
    logic           i_rst_n;
    logic [N-1:0]   i_num;
    logic [SHW-1:0] i_num_bit_rotation;
    logic           i_valid;
    logic           o_ready;
    logic [N-1:0]   o_result;
    logic           o_valid;
    logic           i_ready;
    logic           o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] exp_q[$];

    rotation_left_shifter_seq #(.N(N)) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_num              (i_num),
        .i_num_bit_rotation (i_num_bit_rotation),
        .i_valid            (i_valid),
        .o_ready            (o_ready),
        .o_result           (o_result),
        .o_valid            (o_valid),
        .i_ready            (i_ready),
        .o_busy             (o_busy)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // reference model
    function automatic logic [N-1:0] ref_rotl(input logic [N-1:0] x, input int a);
        logic [2*N-1:0] w;
        w = {x, x} << a;
        return w[2*N-1:N];
    endfunction

    function automatic logic [N-1:0] ref_rotr(input logic [N-1:0] x, input int a);
        logic [2*N-1:0] w;
        w = {x, x} >> a;
        return w[N-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation with i_ready high: checks acceptance, fixed latency,
    // single-cycle o_valid pulse and the rotated value.
    task automatic do_op(input logic [N-1:0] x, input logic [SHW-1:0] a, input bit full);
        logic [N-1:0] expv;
        expv = ref_rotl(x, int'(a));
        @(negedge i_clk);
        i_num = x;
        i_num_bit_rotation = a;
        i_valid = 1'b1;
        i_ready = 1'b1;
        if (full) check("ready_idle", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_num = N'($urandom);
        i_num_bit_rotation = SHW'($urandom);
        if (full) check("busy_after_accept", {31'd0, o_busy}, 32'd1);
        for (int e = 1; e <= SHW; e++) begin
            @(posedge i_clk);
            #1;
            if (e < SHW) begin
                if (full) check("valid_early", {31'd0, o_valid}, 32'd0);
            end else begin
                check("valid_latency", {31'd0, o_valid}, 32'd1);
                check("result", {24'd0, o_result}, {24'd0, expv});
                check("roundtrip", {24'd0, ref_rotr(o_result, int'(a))}, {24'd0, x});
            end
        end
        @(posedge i_clk);
        #1;
        check("valid_pulse", {31'd0, o_valid}, 32'd0);
        if (full) check("ready_back", {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        int acc_cnt, res_cnt, cyc, last_acc;
        logic [N-1:0] x;
        logic [SHW-1:0] a;

        i_rst_n = 1'b0;
        i_num = '0;
        i_num_bit_rotation = '0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_result", {24'd0, o_result}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // directed values
        do_op(8'hA5, 3'd1, 1'b1);
        do_op(8'h01, 3'd7, 1'b1);
        do_op(8'h12, 3'd4, 1'b1);
        do_op(8'h3C, 3'd0, 1'b1);

        // backpressure: hold result, ignore requests while DONE
        @(negedge i_clk);
        i_num = 8'hA5;
        i_num_bit_rotation = 3'd1;
        i_valid = 1'b1;
        i_ready = 1'b0;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (SHW) @(posedge i_clk);
        #1;
        check("bp_valid_rise", {31'd0, o_valid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            i_valid = c[0];
            i_num = 8'hFF;
            i_num_bit_rotation = 3'd3;
            @(posedge i_clk);
            #1;
            check("bp_valid_hold", {31'd0, o_valid}, 32'd1);
            check("bp_result_hold", {24'd0, o_result}, 32'h4B);
            check("bp_not_ready", {31'd0, o_ready}, 32'd0);
        end
        @(negedge i_clk);
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_num = 8'hF0;
        i_num_bit_rotation = 3'd2;
        @(posedge i_clk);
        #1;
        check("bp_exit_valid", {31'd0, o_valid}, 32'd0);
        check("bp_exit_idle", {31'd0, o_busy}, 32'd0);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        check("bp_next_accept", {31'd0, o_busy}, 32'd1);
        repeat (SHW) @(posedge i_clk);
        #1;
        check("bp_next_valid", {31'd0, o_valid}, 32'd1);
        check("bp_next_result", {24'd0, o_result}, {24'd0, ref_rotl(8'hF0, 2)});
        @(posedge i_clk);
        #1;

        // reset in the middle of SHIFT
        @(negedge i_clk);
        i_num = 8'h81;
        i_num_bit_rotation = 3'd3;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check("mid_rst_result", {24'd0, o_result}, 32'd0);
        check("mid_rst_ready", {31'd0, o_ready}, 32'd1);
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge i_clk);
            #1;
            check("no_stale_valid", {31'd0, o_valid}, 32'd0);
        end

        // every word with every amount
        for (int w = 0; w < 256; w++) begin
            for (int s = 0; s < 8; s++) begin
                do_op(N'(w), SHW'(s), 1'b0);
            end
        end

        // random operations
        for (int r = 0; r < 20; r++) begin
            do_op(N'($urandom), SHW'($urandom_range(0, 7)), 1'b1);
        end

        // streaming with i_valid held high
        acc_cnt = 0;
        res_cnt = 0;
        last_acc = -1;
        cyc = 0;
        i_ready = 1'b1;
        i_valid = 1'b1;
        while ((res_cnt < 10) && (cyc < 200)) begin
            @(negedge i_clk);
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected", {24'd0, o_result}, 32'hFFFF_FFFF);
                end else begin
                    check("stream_result", {24'd0, o_result}, {24'd0, exp_q.pop_front()});
                end
                res_cnt++;
            end
            if (o_ready && (acc_cnt < 10)) begin
                x = N'($urandom);
                a = SHW'($urandom_range(0, 7));
                i_num = x;
                i_num_bit_rotation = a;
                exp_q.push_back(ref_rotl(x, int'(a)));
                if (last_acc >= 0) check("stream_gap", 32'(cyc - last_acc), 32'(SHW + 2));
                last_acc = cyc;
                acc_cnt++;
            end else begin
                i_num = N'($urandom);
                i_num_bit_rotation = SHW'($urandom);
                if (acc_cnt >= 10) i_valid = 1'b0;
            end
            cyc++;
        end
        i_valid = 1'b0;
        check("stream_count", 32'(res_cnt), 32'd10);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
